sd_mirror_fifo: RTL and testbench

SD_MIRROR_FIFO -- requirements
Module: sd_mirror_fifo

---
 rtl/sd_mirror_pkg.sv | 19 +
 rtl/sd_mirror_rdport.sv | 35 +++
 rtl/sd_mirror_fifo.sv | 91 +++++++++
 tb/tb_sd_mirror_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sd_mirror_pkg.sv
// Shared helpers for the mirrored FIFO: pointer width and broadcast mask.
package sd_mirror_pkg;

  localparam int unsigned MAX_MIRROR = 16;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [MAX_MIRROR-1:0] bcast_mask(input int unsigned mirror);
    logic [MAX_MIRROR-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_MIRROR; i++)
      m[i] = (i < mirror);
    return m;
  endfunction

endpackage

// File: rtl/sd_mirror_rdport.sv
// Per-channel read pointer: delivers entries destined for this channel and skips the others.
module sd_mirror_rdport
  import sd_mirror_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ptr_width(depth)-1:0]   wr_ptr,
  input  logic                          pend_bit,
  input  logic                          p_drdy,
  output logic                          p_srdy,
  output logic                          clr,
  output logic [ptr_width(depth)-2:0]   rd_idx
);

  localparam int unsigned pw = ptr_width(depth);

  logic [pw-1:0] rd_ptr;
  logic          avail;

  assign avail  = (rd_ptr != wr_ptr);
  assign p_srdy = avail & pend_bit;
  assign clr    = p_srdy & p_drdy;
  assign rd_idx = rd_ptr[pw-2:0];

  // Entries not destined here cost one bubble cycle each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_ptr <= '0;
    else if (avail && (!pend_bit || p_drdy))
      rd_ptr <= rd_ptr + 1'b1;
  end

endmodule

// File: rtl/sd_mirror_fifo.sv
// Shared-buffer FIFO mirroring each item to a masked set of output channels.
// Optional occupancy output enabled by defining SD_MIRROR_FIFO_USAGE_EN.
module sd_mirror_fifo
  import sd_mirror_pkg::*;
#(
  parameter int unsigned mirror = 2,
  parameter int unsigned width  = 128,
  parameter int unsigned depth  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef SD_MIRROR_FIFO_USAGE_EN
  output logic [$clog2(depth):0]    usage,
`endif
  input  logic                      c_srdy,
  output logic                      c_drdy,
  input  logic [width-1:0]          c_data,
  input  logic [mirror-1:0]         c_dst_vld,
  output logic [mirror-1:0]         p_srdy,
  input  logic [mirror-1:0]         p_drdy,
  output logic [mirror*width-1:0]   p_data
);

  localparam int unsigned pw = ptr_width(depth);
  localparam int unsigned aw = pw - 1;
  localparam logic [MAX_MIRROR-1:0] bcast = bcast_mask(mirror);

  logic [width-1:0]  mem     [depth];
  logic [mirror-1:0] pending [depth];
  logic [pw-1:0]     wr_ptr, free_ptr, occ;
  logic [aw-1:0]     rd_idx  [mirror];
  logic [mirror-1:0] pend_bit, clr, wr_mask;
  logic              wr_en, free_en;

  assign occ     = wr_ptr - free_ptr;
  assign c_drdy  = (occ < pw'(depth));
  assign wr_en   = c_srdy & c_drdy;
  assign wr_mask = (c_dst_vld == '0) ? bcast[mirror-1:0] : c_dst_vld;
  assign free_en = (free_ptr != wr_ptr) && (pending[free_ptr[aw-1:0]] == '0);

`ifdef SD_MIRROR_FIFO_USAGE_EN
  assign usage = occ;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      free_ptr <= '0;
    end else begin
      if (wr_en)   wr_ptr   <= wr_ptr + 1'b1;
      if (free_en) free_ptr <= free_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[aw-1:0]] <= c_data;
  end

  // A write only targets a freed slot, and every reader is already past it,
  // so write-set and read-clear never hit the same entry in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned e = 0; e < depth; e++)
        pending[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < depth; e++)
        for (int unsigned i = 0; i < mirror; i++)
          if (wr_en && (wr_ptr[aw-1:0] == aw'(e)))
            pending[e][i] <= wr_mask[i];
          else if (clr[i] && (rd_idx[i] == aw'(e)))
            pending[e][i] <= 1'b0;
    end
  end

  for (genvar g = 0; g < mirror; g++) begin : g_ch
    assign pend_bit[g]               = pending[rd_idx[g]][g];
    assign p_data[g*width +: width]  = mem[rd_idx[g]];

    sd_mirror_rdport #(.depth(depth)) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .wr_ptr   (wr_ptr),
      .pend_bit (pend_bit[g]),
      .p_drdy   (p_drdy[g]),
      .p_srdy   (p_srdy[g]),
      .clr      (clr[g]),
      .rd_idx   (rd_idx[g])
    );
  end

endmodule

// File: tb/tb_sd_mirror_fifo.sv
// Directed vector table plus reset and randomized scoreboard sequences for sd_mirror_fifo.
module tb_sd_mirror_fifo;

  localparam int unsigned M = 2;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           c_srdy, c_drdy;
  logic [W-1:0]   c_data;
  logic [M-1:0]   c_dst_vld, p_srdy, p_drdy;
  logic [M*W-1:0] p_data;
`ifdef SD_MIRROR_FIFO_USAGE_EN
  logic [2:0]     usage;
`endif

  int vectors = 0;
  int miscompares = 0;

  sd_mirror_fifo #(.mirror(M), .width(W), .depth(D)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SD_MIRROR_FIFO_USAGE_EN
    .usage     (usage),
`endif
    .c_srdy    (c_srdy),
    .c_drdy    (c_drdy),
    .c_data    (c_data),
    .c_dst_vld (c_dst_vld),
    .p_srdy    (p_srdy),
    .p_drdy    (p_drdy),
    .p_data    (p_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        srdy;
    logic [15:0] data;
    logic [1:0]  dst;
    logic [1:0]  drdy;
    logic        e_drdy;
    logic [1:0]  e_srdy;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic [2:0]  e_use;
  } vec_t;

  vec_t tv [24];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare one negedge sample against the per-channel queues, then record any write.
  task automatic sample(input logic allow_push);
    if (p_srdy[0]) begin
      if (q0.size() == 0) check("ch0 spurious p_srdy", 32'(p_srdy[0]), 32'd0);
      else if (p_drdy[0]) check("ch0 order", 32'(p_data[15:0]), 32'(q0.pop_front()));
    end
    if (p_srdy[1]) begin
      if (q1.size() == 0) check("ch1 spurious p_srdy", 32'(p_srdy[1]), 32'd0);
      else if (p_drdy[1]) check("ch1 order", 32'(p_data[31:16]), 32'(q1.pop_front()));
    end
    if (allow_push && c_srdy && c_drdy) begin
      if (c_dst_vld == 2'b00 || c_dst_vld[0]) q0.push_back(c_data);
      if (c_dst_vld == 2'b00 || c_dst_vld[1]) q1.push_back(c_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            srdy data      dst    drdy   e_drdy e_srdy e_d0      e_d1      use
    tv[0]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[1]  = '{1'b1, 16'hA001, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[2]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b11, 16'hA001, 16'hA001, 3'd1};
    tv[3]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd1};
    tv[4]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[5]  = '{1'b1, 16'hB001, 2'b01, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[6]  = '{1'b1, 16'hB002, 2'b10, 2'b11, 1'b1, 2'b01, 16'hB001, 16'h0000, 3'd1};
    tv[7]  = '{1'b1, 16'hB003, 2'b01, 2'b11, 1'b1, 2'b10, 16'h0000, 16'hB002, 3'd2};
    tv[8]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b01, 16'hB003, 16'h0000, 3'd2};
    tv[9]  = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd1};
    tv[10] = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[11] = '{1'b1, 16'hC001, 2'b11, 2'b01, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};
    tv[12] = '{1'b1, 16'hC002, 2'b11, 2'b01, 1'b1, 2'b11, 16'hC001, 16'hC001, 3'd1};
    tv[13] = '{1'b1, 16'hC003, 2'b11, 2'b01, 1'b1, 2'b11, 16'hC002, 16'hC001, 3'd2};
    tv[14] = '{1'b1, 16'hC004, 2'b11, 2'b01, 1'b1, 2'b11, 16'hC003, 16'hC001, 3'd3};
    tv[15] = '{1'b1, 16'hC005, 2'b11, 2'b01, 1'b0, 2'b11, 16'hC004, 16'hC001, 3'd4};
    tv[16] = '{1'b1, 16'hC005, 2'b11, 2'b01, 1'b0, 2'b10, 16'h0000, 16'hC001, 3'd4};
    tv[17] = '{1'b1, 16'hC005, 2'b11, 2'b11, 1'b0, 2'b10, 16'h0000, 16'hC001, 3'd4};
    tv[18] = '{1'b1, 16'hC005, 2'b11, 2'b11, 1'b0, 2'b10, 16'h0000, 16'hC002, 3'd4};
    tv[19] = '{1'b1, 16'hC005, 2'b11, 2'b11, 1'b1, 2'b10, 16'h0000, 16'hC003, 3'd3};
    tv[20] = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b11, 16'hC005, 16'hC004, 3'd3};
    tv[21] = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b10, 16'h0000, 16'hC005, 3'd2};
    tv[22] = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd1};
    tv[23] = '{1'b0, 16'h0000, 2'b00, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0};

    reset = 1'b1; c_srdy = 1'b0; c_data = '0; c_dst_vld = '0; p_drdy = '0;
    #1;
    check("reset p_srdy", 32'(p_srdy), 32'd0);
    check("reset c_drdy", 32'(c_drdy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      c_srdy = tv[i].srdy; c_data = tv[i].data; c_dst_vld = tv[i].dst; p_drdy = tv[i].drdy;
      @(negedge clk);
      check($sformatf("v%0d c_drdy", i), 32'(c_drdy), 32'(tv[i].e_drdy));
      check($sformatf("v%0d p_srdy", i), 32'(p_srdy), 32'(tv[i].e_srdy));
      if (tv[i].e_srdy[0]) check($sformatf("v%0d p_data0", i), 32'(p_data[15:0]), 32'(tv[i].e_d0));
      if (tv[i].e_srdy[1]) check($sformatf("v%0d p_data1", i), 32'(p_data[31:16]), 32'(tv[i].e_d1));
`ifdef SD_MIRROR_FIFO_USAGE_EN
      check($sformatf("v%0d usage", i), 32'(usage), 32'(tv[i].e_use));
`endif
      @(posedge clk); #1;
    end

    // Reset while three broadcast items wait on both stalled channels.
    p_drdy = 2'b00; c_dst_vld = 2'b00;
    for (int i = 0; i < 3; i++) begin
      c_srdy = 1'b1; c_data = 16'hD000 + 16'(i);
      @(posedge clk); #1;
    end
    c_srdy = 1'b0;
    @(negedge clk);
    check("pre-reset p_srdy", 32'(p_srdy), 32'd3);
    check("pre-reset p_data0", 32'(p_data[15:0]), 32'hD000);
    #2 reset = 1'b1;
    #1;
    check("async reset p_srdy", 32'(p_srdy), 32'd0);
    check("async reset c_drdy", 32'(c_drdy), 32'd1);
`ifdef SD_MIRROR_FIFO_USAGE_EN
    check("async reset usage", 32'(usage), 32'd0);
`endif
    @(negedge clk) reset = 1'b0;
    p_drdy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-reset p_srdy %0d", i), 32'(p_srdy), 32'd0);
      check($sformatf("post-reset c_drdy %0d", i), 32'(c_drdy), 32'd1);
    end
    @(posedge clk); #1;

    // Random traffic and backpressure against per-channel queues.
    begin
      int written;
      written = 0;
      for (int cyc = 0; cyc < 20000 && written < 2000; cyc++) begin
        c_srdy    = ($urandom_range(0, 3) != 0);
        c_data    = 16'($urandom);
        c_dst_vld = 2'($urandom);
        p_drdy    = 2'($urandom);
        @(negedge clk);
        if (c_srdy && c_drdy) written++;
        sample(1'b1);
        @(posedge clk); #1;
      end
      check("random items written", 32'(written), 32'd2000);
    end

    c_srdy = 1'b0; p_drdy = 2'b11;
    for (int cyc = 0; cyc < 200 && (q0.size() + q1.size()) > 0; cyc++) begin
      @(negedge clk);
      sample(1'b0);
      @(posedge clk); #1;
    end
    check("ch0 drained", 32'(q0.size()), 32'd0);
    check("ch1 drained", 32'(q1.size()), 32'd0);
    @(negedge clk);
    check("final p_srdy", 32'(p_srdy), 32'd0);
    check("final c_drdy", 32'(c_drdy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
